// File: rtl/regs_wr_arbiter.sv
// Register-file write-port arbiter: execute-stage writes always win; debug (jtag)
// writes queue in a 2-entry FIFO and drain on free cycles, with a starve-driven hold.
module regs_wr_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_we_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        jtag_req_i,
   input  logic [4:0]  jtag_addr_i,
   input  logic [31:0] jtag_data_i,
   output logic        jtag_ready_o,
   output logic        we_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o,
   output logic        hold_o,
   output logic        jtag_done_o,
   output logic [1:0]  fifo_count_o
);

   localparam logic [2:0] LP_LIMIT = 3'(STARVE_LIMIT);
   localparam int         LP_DEPTH = 2;

   logic [4:0]  r_fifo_addr [LP_DEPTH];
   logic [31:0] r_fifo_data [LP_DEPTH];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_fifo_count;
   logic [2:0]  r_starve;

   logic        w_ex_valid;
   logic        w_fifo_nempty;
   logic        w_fifo_full;
   logic        w_ready;
   logic        w_enq;
   logic        w_deq;
   logic [1:0]  w_count_next;
   logic [2:0]  w_starve_next;
   logic [4:0]  w_head_addr;
   logic [31:0] w_head_data;

   assign w_ex_valid    = ex_we_i && (ex_waddr_i != 5'd0);
   assign w_fifo_nempty = (r_fifo_count != 2'd0);
   assign w_fifo_full   = (r_fifo_count == 2'd2);

   // Ready comes from the registered count only; it is forced low while reset is held.
   assign w_ready = !rst && !w_fifo_full;

   // Writes to x0 complete the handshake but never enter the FIFO.
   assign w_enq = jtag_req_i && w_ready && (jtag_addr_i != 5'd0);
   assign w_deq = !w_ex_valid && w_fifo_nempty;

   assign w_head_addr = r_fifo_addr[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   always_comb begin
      w_count_next = r_fifo_count;
      case ({w_enq, w_deq})
         2'b10:   w_count_next = r_fifo_count + 2'd1;
         2'b01:   w_count_next = r_fifo_count - 2'd1;
         default: w_count_next = r_fifo_count;
      endcase
   end

   always_comb begin
      w_starve_next = r_starve;
      if (!w_fifo_nempty || w_deq) begin
         w_starve_next = 3'd0;
      end else if (r_starve != LP_LIMIT) begin
         w_starve_next = r_starve + 3'd1;
      end
   end

   // The ex path is purely combinational so it never sees added latency.
   always_comb begin
      we_o        = 1'b0;
      waddr_o     = 5'd0;
      wdata_o     = 32'd0;
      jtag_done_o = 1'b0;
      if (w_ex_valid) begin
         we_o    = 1'b1;
         waddr_o = ex_waddr_i;
         wdata_o = ex_wdata_i;
      end else if (w_fifo_nempty) begin
         we_o        = 1'b1;
         waddr_o     = w_head_addr;
         wdata_o     = w_head_data;
         jtag_done_o = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LP_DEPTH; gi++) begin : g_entry
         logic w_wr_sel;
         assign w_wr_sel = w_enq && (r_wr_ptr == 1'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_fifo_addr[gi] <= 5'd0;
               r_fifo_data[gi] <= 32'd0;
            end else if (w_wr_sel) begin
               r_fifo_addr[gi] <= jtag_addr_i;
               r_fifo_data[gi] <= jtag_data_i;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_fifo_count <= 2'd0;
         r_starve     <= 3'd0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_deq) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_fifo_count <= w_count_next;
         r_starve     <= w_starve_next;
      end
   end

   assign jtag_ready_o = w_ready;
   assign hold_o       = (r_starve == LP_LIMIT);
   assign fifo_count_o = r_fifo_count;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter with hand-computed expectations (STARVE_LIMIT=4).
module tb_regs_wr_arbiter;

   logic        clk;
   logic        rst;
   logic        ex_we_i;
   logic [4:0]  ex_waddr_i;
   logic [31:0] ex_wdata_i;
   logic        jtag_req_i;
   logic [4:0]  jtag_addr_i;
   logic [31:0] jtag_data_i;
   logic        jtag_ready_o;
   logic        we_o;
   logic [4:0]  waddr_o;
   logic [31:0] wdata_o;
   logic        hold_o;
   logic        jtag_done_o;
   logic [1:0]  fifo_count_o;

   int n_cmp = 0;
   int n_err = 0;

   regs_wr_arbiter #(.STARVE_LIMIT(4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .ex_we_i      (ex_we_i),
      .ex_waddr_i   (ex_waddr_i),
      .ex_wdata_i   (ex_wdata_i),
      .jtag_req_i   (jtag_req_i),
      .jtag_addr_i  (jtag_addr_i),
      .jtag_data_i  (jtag_data_i),
      .jtag_ready_o (jtag_ready_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .hold_o       (hold_o),
      .jtag_done_o  (jtag_done_o),
      .fifo_count_o (fifo_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic we, input logic [4:0] a, input logic [31:0] d);
      ex_we_i = we; ex_waddr_i = a; ex_wdata_i = d;
   endtask

   task automatic set_jtag(input logic req, input logic [4:0] a, input logic [31:0] d);
      jtag_req_i = req; jtag_addr_i = a; jtag_data_i = d;
   endtask

   task automatic chk_port(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic done);
      chk({tag, ".we"},   32'(we_o),        32'(we));
      chk({tag, ".addr"}, 32'(waddr_o),     32'(a));
      chk({tag, ".data"}, wdata_o,          d);
      chk({tag, ".done"}, 32'(jtag_done_o), 32'(done));
   endtask

   initial begin
      rst = 1'b1;
      set_ex(1'b0, 5'd0, 32'd0);
      set_jtag(1'b0, 5'd0, 32'd0);

      // Reset behaviour: ex path still live, jtag side quiescent.
      tick(); tick();
      set_ex(1'b1, 5'd7, 32'h0000_0070);
      set_jtag(1'b1, 5'd2, 32'h2222_2222);
      #1;
      chk("rst.ready", 32'(jtag_ready_o), 32'd0);
      chk("rst.hold",  32'(hold_o),       32'd0);
      chk("rst.count", 32'(fifo_count_o), 32'd0);
      chk_port("rst.port", 1'b1, 5'd7, 32'h0000_0070, 1'b0);
      tick();
      set_ex(1'b0, 5'd0, 32'd0);
      set_jtag(1'b0, 5'd0, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst.ready", 32'(jtag_ready_o), 32'd1);
      chk_port("post_rst.idle", 1'b0, 5'd0, 32'd0, 1'b0);

      // Single jtag write on an idle port: written the next cycle, no bypass.
      tick();
      set_jtag(1'b1, 5'd5, 32'hA5A5_A5A5);
      #1;
      chk("t1.ready", 32'(jtag_ready_o), 32'd1);
      chk_port("t1.c0", 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      set_jtag(1'b0, 5'd0, 32'd0);
      #1;
      chk("t1.c1.count", 32'(fifo_count_o), 32'd1);
      chk_port("t1.c1", 1'b1, 5'd5, 32'hA5A5_A5A5, 1'b1);
      tick(); #1;
      chk("t1.c2.count", 32'(fifo_count_o), 32'd0);
      chk_port("t1.c2", 1'b0, 5'd0, 32'd0, 1'b0);

      // Starvation: ex writes x3 continuously while one jtag entry waits.
      tick();
      set_ex(1'b1, 5'd3, 32'h0000_0033);
      set_jtag(1'b1, 5'd9, 32'h0000_0099);
      #1;
      chk_port("t2.c0", 1'b1, 5'd3, 32'h0000_0033, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         set_jtag(1'b0, 5'd0, 32'd0);
         #1;
         chk($sformatf("t2.c%0d.hold", i), 32'(hold_o), (i >= 5) ? 32'd1 : 32'd0);
         chk($sformatf("t2.c%0d.addr", i), 32'(waddr_o), 32'd3);
         chk($sformatf("t2.c%0d.done", i), 32'(jtag_done_o), 32'd0);
      end
      tick();
      set_ex(1'b0, 5'd0, 32'd0);
      #1;
      chk_port("t2.c7", 1'b1, 5'd9, 32'h0000_0099, 1'b1);
      chk("t2.c7.hold", 32'(hold_o), 32'd1);
      tick(); #1;
      chk("t2.c8.hold",  32'(hold_o),       32'd0);
      chk("t2.c8.count", 32'(fifo_count_o), 32'd0);

      // Three back-to-back requests while ex is busy; the third waits for room.
      tick();
      set_ex(1'b1, 5'd4, 32'h0000_0044);
      set_jtag(1'b1, 5'd10, 32'h0000_00A0);
      #1;
      chk("t3.c0.ready", 32'(jtag_ready_o), 32'd1);
      tick();
      set_jtag(1'b1, 5'd11, 32'h0000_00B0);
      #1;
      chk("t3.c1.ready", 32'(jtag_ready_o), 32'd1);
      chk("t3.c1.count", 32'(fifo_count_o), 32'd1);
      tick();
      set_jtag(1'b1, 5'd12, 32'h0000_00C0);
      #1;
      chk("t3.c2.ready", 32'(jtag_ready_o), 32'd0);
      chk("t3.c2.count", 32'(fifo_count_o), 32'd2);
      chk_port("t3.c2", 1'b1, 5'd4, 32'h0000_0044, 1'b0);
      // Full FIFO and a free port: dequeue only, request not taken this cycle.
      tick();
      set_ex(1'b0, 5'd0, 32'd0);
      #1;
      chk("t3.c3.ready", 32'(jtag_ready_o), 32'd0);
      chk_port("t3.c3", 1'b1, 5'd10, 32'h0000_00A0, 1'b1);
      tick(); #1;
      chk("t3.c4.count", 32'(fifo_count_o), 32'd1);
      chk("t3.c4.ready", 32'(jtag_ready_o), 32'd1);
      chk_port("t3.c4", 1'b1, 5'd11, 32'h0000_00B0, 1'b1);
      tick();
      set_jtag(1'b0, 5'd0, 32'd0);
      #1;
      chk("t3.c5.count", 32'(fifo_count_o), 32'd1);
      chk_port("t3.c5", 1'b1, 5'd12, 32'h0000_00C0, 1'b1);
      tick(); #1;
      chk("t3.c6.count", 32'(fifo_count_o), 32'd0);

      // x0 handling on both sides.
      set_jtag(1'b1, 5'd0, 32'h0000_DEAD);
      #1;
      chk("t4.c0.ready", 32'(jtag_ready_o), 32'd1);
      tick();
      set_jtag(1'b0, 5'd0, 32'd0);
      #1;
      chk("t4.c1.count", 32'(fifo_count_o), 32'd0);
      chk_port("t4.c1", 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      set_ex(1'b1, 5'd0, 32'h0000_0077);
      set_jtag(1'b1, 5'd6, 32'h0000_0066);
      #1;
      chk_port("t4.c2", 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      set_jtag(1'b0, 5'd0, 32'd0);
      #1;
      chk_port("t4.c3", 1'b1, 5'd6, 32'h0000_0066, 1'b1);

      // Two writes to one address drain in order.
      tick();
      set_ex(1'b1, 5'd1, 32'h0000_0011);
      set_jtag(1'b1, 5'd8, 32'h0000_0001);
      tick();
      set_jtag(1'b1, 5'd8, 32'h0000_0002);
      tick();
      set_ex(1'b0, 5'd0, 32'd0);
      set_jtag(1'b0, 5'd0, 32'd0);
      #1;
      chk_port("t5.first", 1'b1, 5'd8, 32'h0000_0001, 1'b1);
      tick(); #1;
      chk_port("t5.second", 1'b1, 5'd8, 32'h0000_0002, 1'b1);
      tick(); #1;
      chk("t5.count", 32'(fifo_count_o), 32'd0);

      // Reset mid-cycle with two entries buffered and hold asserted.
      set_ex(1'b1, 5'd2, 32'h0000_0022);
      set_jtag(1'b1, 5'd13, 32'h0000_00D0);
      tick();
      set_jtag(1'b1, 5'd14, 32'h0000_00E0);
      tick();
      set_jtag(1'b0, 5'd0, 32'd0);
      tick(); tick(); tick();
      #1;
      chk("t6.pre.count", 32'(fifo_count_o), 32'd2);
      chk("t6.pre.hold",  32'(hold_o),       32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6.rst.count", 32'(fifo_count_o), 32'd0);
      chk("t6.rst.hold",  32'(hold_o),       32'd0);
      chk("t6.rst.ready", 32'(jtag_ready_o), 32'd0);
      set_ex(1'b0, 5'd0, 32'd0);
      #1;
      chk_port("t6.rst.port", 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk($sformatf("t6.after%0d.we", i),   32'(we_o),        32'd0);
         chk($sformatf("t6.after%0d.done", i), 32'(jtag_done_o), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
